// File: rtl/bus_fabric_if.sv
// rtl/bus_fabric_if.sv - master-side and slave-side signal bundle for bus_fabric
interface bus_fabric_if #(
  parameter int NSLAVE = 2,
  parameter int AW     = 32,
  parameter int DW     = 32
);
  logic                 m_req;
  logic [AW-1:0]        m_addr;
  logic                 m_write;
  logic [DW-1:0]        m_wdata;
  logic                 m_busy;
  logic                 m_done;
  logic [DW-1:0]        m_rdata;
  logic                 m_err;
  logic [NSLAVE-1:0]    s_sel;
  logic [AW-1:0]        s_addr;
  logic                 s_write;
  logic [DW-1:0]        s_wdata;
  logic [NSLAVE*DW-1:0] s_rdata;
  logic [NSLAVE-1:0]    s_ready;

  modport master (
    output m_req, m_addr, m_write, m_wdata,
    input  m_busy, m_done, m_rdata, m_err,
    input  s_sel, s_addr, s_write, s_wdata,
    output s_rdata, s_ready
  );

  modport slave (
    input  m_req, m_addr, m_write, m_wdata,
    output m_busy, m_done, m_rdata, m_err,
    output s_sel, s_addr, s_write, s_wdata,
    input  s_rdata, s_ready
  );
endinterface

// File: rtl/bus_fabric.sv
// rtl/bus_fabric.sv - registered base/size address-decoding bus fabric, one access in flight
// Optional access timeout enabled by defining BUS_FABRIC_TIMEOUT_EN.
module bus_fabric #(
  parameter int                   NSLAVE     = 2,
  parameter int                   AW         = 32,
  parameter int                   DW         = 32,
  parameter logic [NSLAVE*AW-1:0] SLAVE_BASE = {32'd411700, 32'd0},
  parameter logic [NSLAVE*AW-1:0] SLAVE_SIZE = {32'd1, 32'd411700},
  parameter int                   TIMEOUT    = 255
) (
  input  logic        clock,
  input  logic        reset,
  bus_fabric_if.slave bus
);

  localparam int IW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic [AW-1:0]   sel_base;
  logic [DW-1:0]   sel_rdata;
  logic            sel_ready;

`ifdef BUS_FABRIC_TIMEOUT_EN
  localparam logic [15:0] TO = 16'(TIMEOUT);
  logic [15:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT);
`endif

  // Descending scan so the lowest-indexed overlapping region wins; AW+1 bits keep BASE+SIZE from wrapping.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if ((SLAVE_SIZE[i*AW +: AW] != '0) &&
          ({1'b0, bus.m_addr} >= {1'b0, SLAVE_BASE[i*AW +: AW]}) &&
          ({1'b0, bus.m_addr} < ({1'b0, SLAVE_BASE[i*AW +: AW]} + {1'b0, SLAVE_SIZE[i*AW +: AW]}))) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign sel_base  = SLAVE_BASE[idx_q*AW +: AW];
  assign sel_rdata = bus.s_rdata[idx_q*DW +: DW];
  assign sel_ready = bus.s_ready[idx_q];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef BUS_FABRIC_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.m_req) begin
          addr_d  = bus.m_addr;
          write_d = bus.m_write;
          wdata_d = bus.m_wdata;
          if (hit) begin
            idx_d   = hit_idx;
            state_d = ACCESS;
`ifdef BUS_FABRIC_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        // Ready on the terminal timeout cycle still completes the access normally.
        if (sel_ready) begin
          rdata_d = write_q ? '0 : sel_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end
`ifdef BUS_FABRIC_TIMEOUT_EN
        else if (cnt_q == TO) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef BUS_FABRIC_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef BUS_FABRIC_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.m_busy  = (state_q != IDLE);
  assign bus.m_done  = (state_q == RESP);
  assign bus.m_rdata = rdata_q;
  assign bus.m_err   = err_q;

  // Slave-side outputs are live only while an access is in progress.
  assign bus.s_sel   = (state_q == ACCESS) ? (NSLAVE'(1) << idx_q) : '0;
  assign bus.s_addr  = (state_q == ACCESS) ? (addr_q - sel_base) : '0;
  assign bus.s_write = (state_q == ACCESS) & write_q;
  assign bus.s_wdata = (state_q == ACCESS) ? wdata_q : '0;

endmodule

// File: tb/tb_bus_fabric.sv
// tb/tb_bus_fabric.sv - directed scoreboard bench for bus_fabric
module tb_bus_fabric;

  logic clk = 1'b0;
  logic rst;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  bus_fabric_if #(.NSLAVE(2), .AW(32), .DW(32)) bus ();

  bus_fabric #(.TIMEOUT(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  `define CHK(tag, obs, exp) \
    begin \
      n_vec++; \
      assert ((obs) === (exp)) else begin \
        n_bad++; \
        $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
      end \
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    `CHK({tag, ".m_busy"},  bus.m_busy,  1'b0)
    `CHK({tag, ".m_done"},  bus.m_done,  1'b0)
    `CHK({tag, ".m_rdata"}, bus.m_rdata, 32'h0)
    `CHK({tag, ".m_err"},   bus.m_err,   1'b0)
    `CHK({tag, ".s_sel"},   bus.s_sel,   2'b00)
    `CHK({tag, ".s_addr"},  bus.s_addr,  32'h0)
    `CHK({tag, ".s_write"}, bus.s_write, 1'b0)
    `CHK({tag, ".s_wdata"}, bus.s_wdata, 32'h0)
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    `CHK({tag, ".m_done"}, bus.m_done, 1'b1)
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $error("FAIL %s.sb: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      `CHK({tag, ".m_rdata"}, bus.m_rdata, e.rdata)
      `CHK({tag, ".m_err"},   bus.m_err,   e.err)
    end
  endtask

  // idx < 0 means decode miss; waits = ACCESS cycles before s_ready.
  task automatic do_txn(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input int idx, input logic [31:0] srd,
                        input int waits, input bit req_while_busy);
    exp_t        e;
    logic [1:0]  exp_sel;
    logic [31:0] exp_saddr;
    e.rdata   = (idx < 0 || wr) ? 32'h0 : srd;
    e.err     = (idx < 0);
    exp_sel   = (idx == 0) ? 2'b01 : (idx == 1) ? 2'b10 : 2'b00;
    exp_saddr = (idx == 1) ? addr - 32'd411700 : addr;
    sb.push_back(e);
    bus.m_req   = 1'b1;
    bus.m_addr  = addr;
    bus.m_write = wr;
    bus.m_wdata = wd;
    tick();
    bus.m_req   = 1'b0;
    if (idx >= 0) begin
      for (int c = 0; c <= waits; c++) begin
        `CHK({tag, ".s_sel"},   bus.s_sel,   exp_sel)
        `CHK({tag, ".s_addr"},  bus.s_addr,  exp_saddr)
        `CHK({tag, ".s_write"}, bus.s_write, wr)
        `CHK({tag, ".s_wdata"}, bus.s_wdata, wd)
        `CHK({tag, ".early_done"}, bus.m_done, 1'b0)
        bus.s_rdata = 64'hBAD0_BAD1_BAD2_BAD3;
        bus.s_rdata[idx*32 +: 32] = srd;
        bus.s_ready = '0;
        if (c < waits) bus.s_ready[1-idx] = 1'b1;
        else           bus.s_ready[idx]   = 1'b1;
        if (req_while_busy) begin
          bus.m_req  = 1'b1;
          bus.m_addr = 32'd411700 - addr;
        end
        tick();
        bus.s_ready = '0;
        bus.m_req   = 1'b0;
      end
    end else begin
      `CHK({tag, ".s_sel"}, bus.s_sel, 2'b00)
    end
    `CHK({tag, ".s_sel_resp"}, bus.s_sel, 2'b00)
    pop_check(tag);
    tick();
    `CHK({tag, ".busy_after"}, bus.m_busy,  1'b0)
    `CHK({tag, ".done_after"}, bus.m_done,  1'b0)
    `CHK({tag, ".rdata_hold"}, bus.m_rdata, e.rdata)
    `CHK({tag, ".err_hold"},   bus.m_err,   e.err)
  endtask

  initial begin
    rst         = 1'b1;
    bus.m_req   = 1'b0;
    bus.m_addr  = '0;
    bus.m_write = 1'b0;
    bus.m_wdata = '0;
    bus.s_rdata = '0;
    bus.s_ready = '0;
    tick();
    tick();
    check_idle_zero("reset");
    rst = 1'b0;
    tick();

    do_txn("rd_ram",  32'd100,    1'b0, 32'h0,        0,  32'hDEADBEEF, 0, 1'b0);
    do_txn("rd_btn",  32'd411700, 1'b0, 32'h0,        1,  32'hCAFE0001, 3, 1'b0);
    do_txn("wr_ram",  32'd411699, 1'b1, 32'h12345678, 0,  32'h55AA55AA, 0, 1'b1);
    do_txn("miss",    32'd411701, 1'b0, 32'h0,        -1, 32'h0,        0, 1'b0);
    do_txn("rd_btn2", 32'd411700, 1'b0, 32'h0,        1,  32'h0BAD_F00D, 1, 1'b0);

    // Abort an access in flight with reset.
    bus.m_req  = 1'b1;
    bus.m_addr = 32'd7;
    bus.m_write = 1'b0;
    tick();
    bus.m_req = 1'b0;
    `CHK("abort.s_sel", bus.s_sel, 2'b01)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("abort");
    tick();
    `CHK("abort.no_done", bus.m_done, 1'b0)
    do_txn("rd_after", 32'd7, 1'b0, 32'h0, 0, 32'h13579BDF, 2, 1'b0);

`ifdef BUS_FABRIC_TIMEOUT_EN
    begin
      exp_t e;
      e.rdata = 32'h0;
      e.err   = 1'b1;
      sb.push_back(e);
      bus.m_req  = 1'b1;
      bus.m_addr = 32'd50;
      tick();
      bus.m_req = 1'b0;
      for (int c = 1; c <= 5; c++) begin
        `CHK("tmo.s_sel", bus.s_sel, 2'b01)
        `CHK("tmo.early_done", bus.m_done, 1'b0)
        tick();
      end
      `CHK("tmo.s_sel_resp", bus.s_sel, 2'b00)
      pop_check("tmo");
      tick();
    end
    do_txn("tmo_edge", 32'd50, 1'b0, 32'h0, 0, 32'h2468ACE0, 4, 1'b0);
`endif

    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
